// File: rtl/h1_arbiter.sv
// h1_arbiter: round-robin arbiter/sequencer sharing one log/sqrt
// interpolation unit between two requesters (the two Box-Muller channels).
//
// Flow: IDLE (grant + latch addr/owner) -> CLR (one-cycle unit_clr)
//       -> WAIT (unit_en high, addr stable, until unit_done)
//       -> RESP (rsp_valid[owner] until rsp_ready[owner]) -> IDLE.
//
// Ports:
//   clk, reset_n            clock, async active-low reset
//   req_valid/req_ready[2]  request handshake, req_ready one-hot, combinational
//   req_addr0/1[16]         per-requester uniform address
//   rsp_valid[2]/rsp_ready  response handshake toward the owner
//   rsp_data[16], rsp_err   shared result, timeout-abort flag
//   unit_clr/en/addr        control of the shared unit
//   unit_result/unit_done   shared unit outputs (done sticky until clr)
//
// Optional feature: define H1_ARB_TIMEOUT_EN to add a WAIT watchdog that
// aborts after TIMEOUT_CYC cycles with rsp_data = 0, rsp_err = 1.
module h1_arbiter #(
  parameter int TIMEOUT_CYC = 64,
  parameter int CNT_W       = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  req_valid,
  input  logic [15:0] req_addr0,
  input  logic [15:0] req_addr1,
  output logic [1:0]  req_ready,
  output logic [1:0]  rsp_valid,
  input  logic [1:0]  rsp_ready,
  output logic [15:0] rsp_data,
  output logic        rsp_err,
  output logic        unit_clr,
  output logic        unit_en,
  output logic [15:0] unit_addr,
  input  logic [15:0] unit_result,
  input  logic        unit_done
);

  if (!((2 ** CNT_W) > TIMEOUT_CYC)) begin : g_cfg_chk
    $error("h1_arbiter: CNT_W too narrow for TIMEOUT_CYC");
  end

  typedef enum logic [1:0] {S_IDLE, S_CLR, S_WAIT, S_RESP} state_e;

  state_e      state_q, state_d;
  logic        ptr_q, ptr_d;
  logic        owner_q, owner_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] data_q, data_d;
  logic        err_q, err_d;
  logic        clr_q, clr_d;
  logic        en_q, en_d;
  logic [1:0]  rv_q, rv_d;
  logic [1:0]  gnt;
`ifdef H1_ARB_TIMEOUT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

  // Single requester wins outright; on contention the pointer decides.
  assign gnt[0] = req_valid[0] & (~req_valid[1] | ~ptr_q);
  assign gnt[1] = req_valid[1] & (~req_valid[0] |  ptr_q);

  // Gated with reset_n so req_ready reads 0 while reset is held.
  assign req_ready = (state_q == S_IDLE && reset_n) ? gnt : 2'b00;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    addr_d  = addr_q;
    data_d  = data_q;
    err_d   = err_q;
`ifdef H1_ARB_TIMEOUT_EN
    cnt_d   = cnt_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (|gnt) begin
          owner_d = gnt[1];
          addr_d  = gnt[1] ? req_addr1 : req_addr0;
          state_d = S_CLR;
        end
      end
      S_CLR: begin
        state_d = S_WAIT;
`ifdef H1_ARB_TIMEOUT_EN
        cnt_d   = '0;
`endif
      end
      S_WAIT: begin
        // done has priority over an expiring watchdog in the same cycle
        if (unit_done) begin
          data_d  = unit_result;
          err_d   = 1'b0;
          state_d = S_RESP;
        end
`ifdef H1_ARB_TIMEOUT_EN
        else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
          data_d  = 16'h0000;
          err_d   = 1'b1;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
`endif
      end
      S_RESP: begin
        if (rsp_ready[owner_q]) begin
          ptr_d   = ~ptr_q;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Outputs registered from the next state so they are glitch-free.
    clr_d = (state_d == S_CLR);
    en_d  = (state_d == S_WAIT);
    rv_d  = (state_d == S_RESP) ? (owner_d ? 2'b10 : 2'b01) : 2'b00;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      ptr_q   <= 1'b0;
      owner_q <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
      clr_q   <= 1'b0;
      en_q    <= 1'b0;
      rv_q    <= 2'b00;
`ifdef H1_ARB_TIMEOUT_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      err_q   <= err_d;
      clr_q   <= clr_d;
      en_q    <= en_d;
      rv_q    <= rv_d;
`ifdef H1_ARB_TIMEOUT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  assign rsp_valid = rv_q;
  assign rsp_data  = data_q;
`ifdef H1_ARB_TIMEOUT_EN
  assign rsp_err   = err_q;
`else
  assign rsp_err   = 1'b0;
`endif
  assign unit_clr  = clr_q;
  assign unit_en   = en_q;
  assign unit_addr = addr_q;

endmodule

// File: tb/tb_h1_arbiter.sv
`timescale 1ns/1ps
// Self-checking bench for h1_arbiter. A behavioural unit model returns
// addr ^ 16'h1888 after a per-job latency and keeps done high until clr.
// The reference model works per job: grant from a pointer variable,
// response after (latency + 1) WAIT cycles, data from the unit function.
module tb_h1_arbiter;
  localparam int TMO = 64;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  req_valid;
  logic [15:0] req_addr0, req_addr1;
  logic [1:0]  req_ready, rsp_valid, rsp_ready;
  logic [15:0] rsp_data, unit_addr, unit_result;
  logic        rsp_err, unit_clr, unit_en, unit_done;

  int n_chk  = 0;
  int n_fail = 0;
  int ptr_m  = 0;
  int u_lat  = 4;
  int u_cnt  = 0;
  int w;

  h1_arbiter #(.TIMEOUT_CYC(TMO), .CNT_W(8)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_addr0(req_addr0), .req_addr1(req_addr1),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_err(rsp_err),
    .unit_clr(unit_clr), .unit_en(unit_en), .unit_addr(unit_addr),
    .unit_result(unit_result), .unit_done(unit_done)
  );

  always #5 clk = ~clk;

  // shared unit model: done u_lat enabled cycles after clr, sticky until clr
  initial begin unit_done = 1'b0; unit_result = 16'h0; end
  always @(posedge clk) begin
    if (unit_clr) begin
      unit_done <= 1'b0;
      u_cnt     <= 0;
    end else if (unit_en && !unit_done) begin
      u_cnt <= u_cnt + 1;
      if (u_cnt + 1 == u_lat) begin
        unit_done   <= 1'b1;
        unit_result <= unit_addr ^ 16'h1888;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One full job: accept, CLR, WAIT, RESP with bp cycles of backpressure.
  task automatic job(input logic [1:0] v, input logic [15:0] a0, input logic [15:0] a1,
                     input int lat, input int bp, output int win);
    int nwait;
    logic [15:0] ea, ed;
    logic ee;
    logic [1:0] oh;
    win   = (v == 2'b11) ? ptr_m : (v[1] ? 1 : 0);
    ea    = win ? a1 : a0;
    oh    = win ? 2'b10 : 2'b01;
    nwait = lat + 1;
    ed    = ea ^ 16'h1888;
    ee    = 1'b0;
`ifdef H1_ARB_TIMEOUT_EN
    if (lat > TMO - 1) begin nwait = TMO; ed = 16'h0; ee = 1'b1; end
`endif
    u_lat = lat; req_valid = v; req_addr0 = a0; req_addr1 = a1; rsp_ready = 2'b00;
    #1 chk("req_ready_grant", 32'(req_ready), 32'(oh));
    @(negedge clk);                       // T+1: CLR
    req_valid = 2'($urandom);             // must be ignored outside IDLE
    chk("clr_pulse", 32'(unit_clr), 1);
    chk("clr_en_low", 32'(unit_en), 0);
    chk("clr_req_ready", 32'(req_ready), 0);
    for (int i = 0; i < nwait; i++) begin
      @(negedge clk);                     // WAIT cycles
      chk("wait_en", 32'(unit_en), 1);
      chk("wait_clr_low", 32'(unit_clr), 0);
      chk("wait_no_rsp", 32'(rsp_valid), 0);
      chk("wait_addr", 32'(unit_addr), 32'(ea));
    end
    @(negedge clk);                       // first RESP cycle
    chk("rsp_valid", 32'(rsp_valid), 32'(oh));
    chk("rsp_data", 32'(rsp_data), 32'(ed));
    chk("rsp_err", 32'(rsp_err), 32'(ee));
    chk("rsp_en_low", 32'(unit_en), 0);
    req_valid = 2'b11;
    for (int i = 0; i < bp; i++) begin
      rsp_ready = ~oh;                    // non-owner ready must be ignored
      #1 chk("bp_req_ready", 32'(req_ready), 0);
      @(negedge clk);
      chk("bp_rsp_valid", 32'(rsp_valid), 32'(oh));
      chk("bp_rsp_data", 32'(rsp_data), 32'(ed));
      chk("bp_no_clr", 32'(unit_clr), 0);
    end
    rsp_ready = oh | 2'($urandom);
    req_valid = 2'b00;
    @(negedge clk);                       // back in IDLE
    chk("idle_rsp_low", 32'(rsp_valid), 0);
    chk("idle_en_low", 32'(unit_en), 0);
    rsp_ready = 2'b00;
    ptr_m ^= 1;
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    reset_n = 1'b0; req_valid = 2'b11; req_addr0 = 16'h0; req_addr1 = 16'h0; rsp_ready = 2'b00;
    repeat (2) @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 0);
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_rsp_data", 32'(rsp_data), 0);
    chk("rst_rsp_err", 32'(rsp_err), 0);
    chk("rst_unit_clr", 32'(unit_clr), 0);
    chk("rst_unit_en", 32'(unit_en), 0);
    chk("rst_unit_addr", 32'(unit_addr), 0);
    req_valid = 2'b00;
    reset_n = 1'b1;
    @(negedge clk);

    // single request, 4-stage unit
    job(2'b01, 16'h1234, 16'h0000, 4, 0, w);
    chk("single_data_const", 32'(16'h1234 ^ 16'h1888), 32'(16'h0ABC));
    // stale done left high from the prior job
    job(2'b10, 16'h0000, 16'hBEEF, 3, 0, w);
    // backpressure: 10 cycles without owner ready
    job(2'b01, 16'h4321, 16'h5555, 4, 10, w);

    // reset mid-WAIT (pointer is 1 here)
    u_lat = 30; req_valid = 2'b01; req_addr0 = 16'hCAFE;
    repeat (4) @(negedge clk);
    req_valid = 2'b00;
    #2 reset_n = 1'b0;
    #1 chk("rst_mid_en", 32'(unit_en), 0);
    chk("rst_mid_rsp", 32'(rsp_valid), 0);
    @(negedge clk);
    reset_n = 1'b1;
    ptr_m = 0;
    @(negedge clk);
    chk("rst_mid_idle_rsp", 32'(rsp_valid), 0);
    chk("rst_mid_idle_en", 32'(unit_en), 0);

    // contention: grant order must alternate starting from 0
    for (int i = 0; i < 4; i++) begin
      job(2'b11, 16'(16'h1000 + i), 16'(16'h2000 + i), 4, 0, w);
      chk("contention_order", 32'(w), 32'(i % 2));
    end

    // random traffic
    for (int i = 0; i < 20; i++)
      job(2'($urandom_range(1, 3)), 16'($urandom), 16'($urandom),
          $urandom_range(1, 8), $urandom_range(0, 3), w);

`ifdef H1_ARB_TIMEOUT_EN
    job(2'b01, 16'h7777, 16'h0000, 1000, 0, w);   // never done: abort
    job(2'b10, 16'h0000, 16'h8888, TMO - 1, 0, w); // done on 64th cycle
    job(2'b01, 16'h9999, 16'h0000, TMO, 1, w);     // one cycle too late
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
